id_ex_fwd_stage: RTL and testbench

Parametrised ID→EX pipeline register with a generalised operand-forwarding network over `NUM_FWD` prioritised sources. It adds a valid bit, load-use hazard detection with bubble insertion, and re-resolution of held operands while stalled. It sits between the decoder and the ALU/EX stage. It replaces the fixed two-source ID/EX register.

---
 rtl/id_ex_fwd_stage.sv | 178 +++++++++++++++++
 tb/tb_id_ex_fwd_stage.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_fwd_stage.sv
// ID->EX pipeline register with a prioritised NUM_FWD-source forwarding network,
// load-use hazard detection (bubble insertion) and operand refresh while stalled.
module id_ex_fwd_stage #(
   parameter int XLEN    = 32,
   parameter int RA_W    = 5,
   parameter int NUM_FWD = 2
) (
   input  logic                      clk_in,
   input  logic                      rst_n_in,
   input  logic                      rdy_in,
   input  logic                      flush_in,
   input  logic                      stall_in,
   input  logic                      id_valid_in,
   input  logic [XLEN-1:0]           id_pc,
   input  logic [RA_W-1:0]           id_rs1_addr,
   input  logic [RA_W-1:0]           id_rs2_addr,
   input  logic [XLEN-1:0]           id_rs1_data,
   input  logic [XLEN-1:0]           id_rs2_data,
   input  logic                      id_rs1_used,
   input  logic                      id_rs2_used,
   input  logic [RA_W-1:0]           id_rd_addr,
   input  logic [XLEN-1:0]           id_imm,
   input  logic [6:0]                id_ins_type,
   input  logic [2:0]                id_ins_details,
   input  logic                      id_ins_diff,
   input  logic [NUM_FWD-1:0]        fwd_valid,
   input  logic [NUM_FWD-1:0]        fwd_ready,
   input  logic [NUM_FWD*RA_W-1:0]   fwd_addr,
   input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
   output logic                      ex_valid,
   output logic [XLEN-1:0]           ex_pc,
   output logic [XLEN-1:0]           ex_imm,
   output logic [RA_W-1:0]           ex_rs1_addr,
   output logic [RA_W-1:0]           ex_rs2_addr,
   output logic [RA_W-1:0]           ex_rd_addr,
   output logic [XLEN-1:0]           ex_rs1_data,
   output logic [XLEN-1:0]           ex_rs2_data,
   output logic [6:0]                ex_ins_type,
   output logic [2:0]                ex_ins_details,
   output logic                      ex_ins_diff,
   output logic                      hazard_stall_out
);

   localparam logic [6:0] INS_ADDI = 7'b0010011;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [RA_W-1:0] rs1_addr;
      logic [RA_W-1:0] rs2_addr;
      logic [RA_W-1:0] rd_addr;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [6:0]      ins_type;
      logic [2:0]      ins_details;
      logic            ins_diff;
   } stage_t;

   typedef struct packed {
      logic            pend;
      logic [XLEN-1:0] data;
   } res_t;

   stage_t stage_q;
   stage_t stage_d;
   res_t   id1_res_s;
   res_t   id2_res_s;
   res_t   ex1_res_s;
   res_t   ex2_res_s;
   logic   hazard_s;

   // A bubble doubles as the reset image so both paths stay identical.
   function automatic stage_t bubble();
      stage_t b;
      b          = '0;
      b.ins_type = INS_ADDI;
      return b;
   endfunction

   // Lowest index wins; x0 short-circuits every source.
   function automatic res_t resolve(
      input logic [RA_W-1:0]         addr,
      input logic [XLEN-1:0]         rf_data,
      input logic [NUM_FWD-1:0]      fv,
      input logic [NUM_FWD-1:0]      fr,
      input logic [NUM_FWD*RA_W-1:0] fa,
      input logic [NUM_FWD*XLEN-1:0] fd
   );
      res_t r;
      logic found;
      r.pend = 1'b0;
      r.data = rf_data;
      found  = 1'b0;
      if (addr == {RA_W{1'b0}}) begin
         r.data = {XLEN{1'b0}};
      end else begin
         for (int i = 0; i < NUM_FWD; i++) begin
            if (!found && fv[i] && (fa[i*RA_W +: RA_W] == addr)) begin
               found = 1'b1;
               if (fr[i]) begin
                  r.data = fd[i*XLEN +: XLEN];
               end else begin
                  r.pend = 1'b1;
               end
            end else begin
               found = found;
            end
         end
      end
      return r;
   endfunction

   // Operand resolution for both the incoming and the held instruction.
   always_comb begin
      id1_res_s = resolve(id_rs1_addr, id_rs1_data, fwd_valid, fwd_ready, fwd_addr, fwd_data);
      id2_res_s = resolve(id_rs2_addr, id_rs2_data, fwd_valid, fwd_ready, fwd_addr, fwd_data);
      ex1_res_s = resolve(stage_q.rs1_addr, stage_q.rs1_data, fwd_valid, fwd_ready, fwd_addr, fwd_data);
      ex2_res_s = resolve(stage_q.rs2_addr, stage_q.rs2_data, fwd_valid, fwd_ready, fwd_addr, fwd_data);
      hazard_s  = id_valid_in && ((id_rs1_used && id1_res_s.pend) ||
                                  (id_rs2_used && id2_res_s.pend));
   end

   assign hazard_stall_out = hazard_s;

   // Next-state selection: rdy, flush, stall (with refresh), hazard, capture.
   always_comb begin
      stage_d = stage_q;
      if (!rdy_in) begin
         stage_d = stage_q;
      end else if (flush_in) begin
         stage_d = bubble();
      end else if (stall_in) begin
         if (stage_q.valid) begin
            stage_d.rs1_data = ex1_res_s.pend ? stage_q.rs1_data : ex1_res_s.data;
            stage_d.rs2_data = ex2_res_s.pend ? stage_q.rs2_data : ex2_res_s.data;
         end else begin
            stage_d = stage_q;
         end
      end else if (hazard_s) begin
         stage_d = bubble();
      end else begin
         stage_d.valid       = id_valid_in;
         stage_d.pc          = id_pc;
         stage_d.imm         = id_imm;
         stage_d.rs1_addr    = id_rs1_addr;
         stage_d.rs2_addr    = id_rs2_addr;
         stage_d.rd_addr     = id_rd_addr;
         stage_d.rs1_data    = id1_res_s.data;
         stage_d.rs2_data    = id2_res_s.data;
         stage_d.ins_type    = id_ins_type;
         stage_d.ins_details = id_ins_details;
         stage_d.ins_diff    = id_ins_diff;
      end
   end

   // Stage register.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         stage_q <= bubble();
      end else begin
         stage_q <= stage_d;
      end
   end

   assign ex_valid       = stage_q.valid;
   assign ex_pc          = stage_q.pc;
   assign ex_imm         = stage_q.imm;
   assign ex_rs1_addr    = stage_q.rs1_addr;
   assign ex_rs2_addr    = stage_q.rs2_addr;
   assign ex_rd_addr     = stage_q.rd_addr;
   assign ex_rs1_data    = stage_q.rs1_data;
   assign ex_rs2_data    = stage_q.rs2_data;
   assign ex_ins_type    = stage_q.ins_type;
   assign ex_ins_details = stage_q.ins_details;
   assign ex_ins_diff    = stage_q.ins_diff;

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// Scoreboard bench for id_ex_fwd_stage: a reference model pushes expected stage
// contents on every drive, popped and compared one edge later.
module tb_id_ex_fwd_stage;

   localparam int XLEN    = 32;
   localparam int RA_W    = 5;
   localparam int NUM_FWD = 2;
   localparam logic [6:0] ADDI = 7'h13;

   logic                    clk_in;
   logic                    rst_n_in;
   logic                    rdy_in;
   logic                    flush_in;
   logic                    stall_in;
   logic                    id_valid_in;
   logic [XLEN-1:0]         id_pc;
   logic [RA_W-1:0]         id_rs1_addr;
   logic [RA_W-1:0]         id_rs2_addr;
   logic [XLEN-1:0]         id_rs1_data;
   logic [XLEN-1:0]         id_rs2_data;
   logic                    id_rs1_used;
   logic                    id_rs2_used;
   logic [RA_W-1:0]         id_rd_addr;
   logic [XLEN-1:0]         id_imm;
   logic [6:0]              id_ins_type;
   logic [2:0]              id_ins_details;
   logic                    id_ins_diff;
   logic [NUM_FWD-1:0]      fwd_valid;
   logic [NUM_FWD-1:0]      fwd_ready;
   logic [NUM_FWD*RA_W-1:0] fwd_addr;
   logic [NUM_FWD*XLEN-1:0] fwd_data;
   logic                    ex_valid;
   logic [XLEN-1:0]         ex_pc;
   logic [XLEN-1:0]         ex_imm;
   logic [RA_W-1:0]         ex_rs1_addr;
   logic [RA_W-1:0]         ex_rs2_addr;
   logic [RA_W-1:0]         ex_rd_addr;
   logic [XLEN-1:0]         ex_rs1_data;
   logic [XLEN-1:0]         ex_rs2_data;
   logic [6:0]              ex_ins_type;
   logic [2:0]              ex_ins_details;
   logic                    ex_ins_diff;
   logic                    hazard_stall_out;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [RA_W-1:0] a1;
      logic [RA_W-1:0] a2;
      logic [RA_W-1:0] rd;
      logic [XLEN-1:0] d1;
      logic [XLEN-1:0] d2;
      logic [6:0]      ty;
      logic [2:0]      f3;
      logic            f7;
   } exp_t;

   exp_t sb_q[$];
   exp_t m;
   int   vec_cnt;
   int   err_cnt;

   id_ex_fwd_stage #(.XLEN(XLEN), .RA_W(RA_W), .NUM_FWD(NUM_FWD)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
      .stall_in(stall_in), .id_valid_in(id_valid_in), .id_pc(id_pc),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd_addr(id_rd_addr), .id_imm(id_imm), .id_ins_type(id_ins_type),
      .id_ins_details(id_ins_details), .id_ins_diff(id_ins_diff),
      .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
      .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_ins_type(ex_ins_type),
      .ex_ins_details(ex_ins_details), .ex_ins_diff(ex_ins_diff),
      .hazard_stall_out(hazard_stall_out)
   );

   // Free-running clock, rising edge active.
   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t bubble_e();
      exp_t b;
      b    = '0;
      b.ty = ADDI;
      return b;
   endfunction

   // Reference resolve: sweep from the oldest source so the youngest match overwrites last.
   function automatic logic [XLEN:0] m_resolve(input logic [RA_W-1:0] a, input logic [XLEN-1:0] rf);
      logic [XLEN:0] r;
      r = {1'b0, rf};
      if (a == 5'd0) return {(XLEN+1){1'b0}};
      for (int i = NUM_FWD-1; i >= 0; i--) begin
         if (fwd_valid[i] && (fwd_addr[i*RA_W +: RA_W] == a))
            r = fwd_ready[i] ? {1'b0, fwd_data[i*XLEN +: XLEN]} : {1'b1, rf};
      end
      return r;
   endfunction

   task automatic compare_out(input string tag, input exp_t e);
      check_val({tag, ".valid"}, 64'(ex_valid), 64'(e.valid));
      check_val({tag, ".pc"}, 64'(ex_pc), 64'(e.pc));
      check_val({tag, ".imm"}, 64'(ex_imm), 64'(e.imm));
      check_val({tag, ".rs1_addr"}, 64'(ex_rs1_addr), 64'(e.a1));
      check_val({tag, ".rs2_addr"}, 64'(ex_rs2_addr), 64'(e.a2));
      check_val({tag, ".rd_addr"}, 64'(ex_rd_addr), 64'(e.rd));
      check_val({tag, ".rs1_data"}, 64'(ex_rs1_data), 64'(e.d1));
      check_val({tag, ".rs2_data"}, 64'(ex_rs2_data), 64'(e.d2));
      check_val({tag, ".ins_type"}, 64'(ex_ins_type), 64'(e.ty));
      check_val({tag, ".ins_details"}, 64'(ex_ins_details), 64'(e.f3));
      check_val({tag, ".ins_diff"}, 64'(ex_ins_diff), 64'(e.f7));
   endtask

   // Called at posedge+1 with inputs set: checks hazard, predicts, clocks, compares.
   task automatic apply(input string tag);
      exp_t          nx;
      exp_t          got;
      logic [XLEN:0] r1;
      logic [XLEN:0] r2;
      logic          hz;
      #1;
      r1 = m_resolve(id_rs1_addr, id_rs1_data);
      r2 = m_resolve(id_rs2_addr, id_rs2_data);
      hz = id_valid_in && ((id_rs1_used && r1[XLEN]) || (id_rs2_used && r2[XLEN]));
      check_val({tag, ".hazard"}, 64'(hazard_stall_out), 64'(hz));
      nx = m;
      if (!rdy_in) begin
         nx = m;
      end else if (flush_in) begin
         nx = bubble_e();
      end else if (stall_in) begin
         if (m.valid) begin
            r1 = m_resolve(m.a1, m.d1);
            r2 = m_resolve(m.a2, m.d2);
            if (!r1[XLEN]) nx.d1 = r1[XLEN-1:0];
            if (!r2[XLEN]) nx.d2 = r2[XLEN-1:0];
         end
      end else if (hz) begin
         nx = bubble_e();
      end else begin
         nx = '{valid: id_valid_in, pc: id_pc, imm: id_imm, a1: id_rs1_addr, a2: id_rs2_addr,
                rd: id_rd_addr, d1: r1[XLEN-1:0], d2: r2[XLEN-1:0], ty: id_ins_type,
                f3: id_ins_details, f7: id_ins_diff};
      end
      sb_q.push_back(nx);
      m = nx;
      @(posedge clk_in);
      #1;
      if (sb_q.size() == 0) begin
         check_val({tag, ".sb_empty"}, 64'd1, 64'd0);
      end else begin
         got = sb_q.pop_front();
         compare_out(tag, got);
      end
   endtask

   task automatic set_fwd(input int i, input logic v, input logic r,
                          input logic [RA_W-1:0] a, input logic [XLEN-1:0] d);
      fwd_valid[i]              = v;
      fwd_ready[i]              = r;
      fwd_addr[i*RA_W +: RA_W]  = a;
      fwd_data[i*XLEN +: XLEN]  = d;
   endtask

   task automatic set_id(input logic v, input logic [XLEN-1:0] pc,
                         input logic [RA_W-1:0] a1, input logic [XLEN-1:0] d1, input logic u1,
                         input logic [RA_W-1:0] a2, input logic [XLEN-1:0] d2, input logic u2);
      id_valid_in    = v;
      id_pc          = pc;
      id_rs1_addr    = a1;
      id_rs1_data    = d1;
      id_rs1_used    = u1;
      id_rs2_addr    = a2;
      id_rs2_data    = d2;
      id_rs2_used    = u2;
      id_rd_addr     = a1 ^ a2;
      id_imm         = pc ^ 32'h5A5A_0000;
      id_ins_type    = 7'h33;
      id_ins_details = pc[2:0];
      id_ins_diff    = pc[3];
   endtask

   initial begin
      vec_cnt  = 0;
      err_cnt  = 0;
      rst_n_in = 1'b0;
      rdy_in   = 1'b1;
      flush_in = 1'b0;
      stall_in = 1'b0;
      fwd_valid = '0;
      fwd_ready = '0;
      fwd_addr  = '0;
      fwd_data  = '0;
      set_id(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
      m = bubble_e();

      #12;
      compare_out("reset", bubble_e());
      rst_n_in = 1'b1;
      @(posedge clk_in);
      #1;

      // Priority: youngest source wins.
      set_fwd(0, 1'b1, 1'b1, 5'd5, 32'h11);
      set_fwd(1, 1'b1, 1'b1, 5'd5, 32'h22);
      set_id(1'b1, 32'h100, 5'd5, 32'hDEAD, 1'b1, 5'd6, 32'h66, 1'b1);
      apply("prio");
      check_val("prio.direct", 64'(ex_rs1_data), 64'h11);
      check_val("prio.rf", 64'(ex_rs2_data), 64'h66);

      // x0 ignores a forwarding match.
      set_fwd(0, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF);
      set_fwd(1, 1'b0, 1'b0, 5'd0, 32'h0);
      set_id(1'b1, 32'h104, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h4321, 1'b1);
      apply("x0");
      check_val("x0.direct", 64'(ex_rs1_data), 64'h0);

      // Load-use: bubble, then capture once data arrives.
      set_fwd(0, 1'b1, 1'b0, 5'd7, 32'h0);
      set_id(1'b1, 32'h108, 5'd1, 32'h1, 1'b1, 5'd7, 32'h77, 1'b1);
      #1;
      check_val("lu.hazard_direct", 64'(hazard_stall_out), 64'd1);
      apply("lu_bubble");
      check_val("lu.bubble_valid", 64'(ex_valid), 64'd0);
      check_val("lu.bubble_type", 64'(ex_ins_type), 64'(ADDI));
      set_fwd(0, 1'b1, 1'b1, 5'd7, 32'hABCD);
      apply("lu_go");
      check_val("lu.rs2", 64'(ex_rs2_data), 64'hABCD);
      check_val("lu.valid", 64'(ex_valid), 64'd1);
      set_fwd(0, 1'b1, 1'b0, 5'd7, 32'h0);
      id_rs2_used = 1'b0;
      apply("lu_unused");

      // Stall refresh from source 1, then hold, then pending keeps data.
      set_fwd(0, 1'b0, 1'b0, 5'd0, 32'h0);
      set_id(1'b1, 32'h200, 5'd3, 32'h1, 1'b1, 5'd4, 32'h44, 1'b1);
      apply("sr_load");
      stall_in = 1'b1;
      set_fwd(1, 1'b1, 1'b1, 5'd3, 32'h99);
      set_id(1'b1, 32'h300, 5'd9, 32'hBAD, 1'b1, 5'd10, 32'hBAD, 1'b1);
      apply("sr_refresh");
      check_val("sr.rs1", 64'(ex_rs1_data), 64'h99);
      check_val("sr.pc", 64'(ex_pc), 64'h200);
      set_fwd(1, 1'b0, 1'b0, 5'd0, 32'h0);
      apply("sr_hold");
      set_fwd(0, 1'b1, 1'b0, 5'd3, 32'h55);
      apply("sr_pend");
      check_val("sr.pend_keep", 64'(ex_rs1_data), 64'h99);

      // Flush beats stall.
      flush_in = 1'b1;
      apply("flush_stall");
      check_val("flush.valid", 64'(ex_valid), 64'd0);
      flush_in = 1'b0;
      stall_in = 1'b0;
      set_fwd(0, 1'b0, 1'b0, 5'd0, 32'h0);
      set_id(1'b1, 32'h400, 5'd2, 32'h22, 1'b1, 5'd8, 32'h88, 1'b1);
      apply("reload");

      // rdy_in low freezes even with a matching source and flush.
      rdy_in = 1'b0;
      set_fwd(0, 1'b1, 1'b1, 5'd2, 32'hCAFE);
      set_id(1'b1, 32'h500, 5'd2, 32'h0, 1'b1, 5'd2, 32'h0, 1'b1);
      apply("rdy_low");
      check_val("rdy.rs1", 64'(ex_rs1_data), 64'h22);
      flush_in = 1'b1;
      apply("rdy_low_flush");
      flush_in = 1'b0;
      rdy_in = 1'b1;

      // Randomised traffic over a small register window to force matches.
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < NUM_FWD; i++)
            set_fwd(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                    5'($urandom_range(0, 7)), $urandom());
         set_id(1'($urandom_range(0, 3) != 0), $urandom(),
                5'($urandom_range(0, 7)), $urandom(), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 7)), $urandom(), 1'($urandom_range(0, 1)));
         rdy_in   = 1'($urandom_range(0, 9) != 0);
         flush_in = 1'($urandom_range(0, 15) == 0);
         stall_in = 1'($urandom_range(0, 4) == 0);
         apply("rand");
      end

      // Asynchronous reset mid-cycle.
      rdy_in   = 1'b1;
      flush_in = 1'b0;
      stall_in = 1'b0;
      set_fwd(0, 1'b0, 1'b0, 5'd0, 32'h0);
      set_fwd(1, 1'b0, 1'b0, 5'd0, 32'h0);
      set_id(1'b1, 32'h600, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b1);
      apply("pre_arst");
      #2;
      rst_n_in = 1'b0;
      #1;
      compare_out("arst", bubble_e());
      m = bubble_e();
      rdy_in = 1'b0;
      @(negedge clk_in);
      rst_n_in = 1'b1;
      @(posedge clk_in);
      #1;
      apply("post_arst_hold");
      rdy_in = 1'b1;
      apply("post_arst_cap");

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
